// File: rtl/bilinear_pkg.sv
// bilinear_pkg: shared defaults, types and FSM encoding for the bilinear downscaler.
package bilinear_pkg;
    localparam int PIX_W_DEF  = 8;
    localparam int FRAC_DEF   = 2;
    localparam int STEP_W_DEF = FRAC_DEF + 4;
    localparam int LAT        = 3;
    typedef logic [STEP_W_DEF-1:0] step_t;
    typedef struct packed {
        logic [PIX_W_DEF-1:0] p22, p12, p21, p11;
    } patch_t;
    typedef enum logic {IDLE, RUN} state_t;
    function automatic int ph_int_w(input int src_w, input int src_h);
        return $clog2(src_w > src_h ? src_w : src_h) + 1;
    endfunction
endpackage

// File: rtl/bilinear_lerp.sv
// bilinear_lerp: registered linear blend (2^F-w)*a + w*b with w in 1/2^F units.
module bilinear_lerp #(
    parameter int W = 8,
    parameter int F = 2
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    input  logic [F-1:0]   i_w,
    output logic [W+F-1:0] o_y
);
    localparam int OW = W + F;
    logic [OW-1:0] y_d, y_q;
    always_comb y_d = (OW'(1 << F) - OW'(i_w)) * OW'(i_a) + OW'(i_w) * OW'(i_b);
    always_ff @(posedge i_clk) y_q <= i_rst ? '0 : y_d;
    assign o_y = y_q;
endmodule

// File: rtl/bilinear_downscaler.sv
// bilinear_downscaler: runtime-ratio bilinear downscaler, one 2x2 patch in, at most one pixel out, 3-cycle latency.
// Define BILINEAR_ROUND_EN for round-half-up output instead of truncation.
module bilinear_downscaler
    import bilinear_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int SRC_W = 640,
    parameter int SRC_H = 480,
    parameter int DST_W = 512,
    parameter int DST_H = 384
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [4*PIX_W-1:0] i_patch,
    input  logic               i_valid,
    input  logic               i_sof,
    input  logic [FRAC+3:0]    i_step_x,
    input  logic [FRAC+3:0]    i_step_y,
    output logic [PIX_W-1:0]   o_data,
    output logic               o_valid,
    output logic               o_sof,
    output logic               o_eol,
    output logic               o_eof,
    output logic               o_err
);
    localparam int SW  = FRAC + 4;
    localparam int PI  = ph_int_w(SRC_W, SRC_H);
    localparam int PW  = PI + FRAC;
    localparam int XW  = $clog2(SRC_W);
    localparam int YW  = $clog2(SRC_H);
    localparam int DXW = $clog2(DST_W + 1);
    localparam int DYW = $clog2(DST_H + 1);
    localparam int AW  = PIX_W + 2 * FRAC;
    localparam logic [SW-1:0] ONE = SW'(1 << FRAC);

    state_t               state_q, state_d;
    logic [XW-1:0]        sx_q, sx_d, sx;
    logic [YW-1:0]        sy_q, sy_d, sy;
    logic [PW-1:0]        nx_q, nx_d, nx, ny_q, ny_d, ny;
    logic [DXW-1:0]       dx_q, dx_d, dx;
    logic [DYW-1:0]       dy_q, dy_d, dy;
    logic [SW-1:0]        stx_q, stx_d, sty_q, sty_d;
    logic [FRAC-1:0]      v_q, v_d;
    logic                 err_q, err_d;
    logic [LAT-1:0][3:0]  mk_q, mk_d;
    logic [PIX_W-1:0]     data_q, data_d;
    logic [PIX_W:0]       rnd;
    logic [PIX_W+FRAC-1:0] top, bot;
    logic [AW-1:0]        acc;
    logic start, act, row_em, col_em, row_end, row_done, last_col, last_row;

    always_comb begin
        start    = i_valid & i_sof;
        act      = i_valid & (start | state_q == RUN);
        sx       = start ? '0 : sx_q;
        sy       = start ? '0 : sy_q;
        nx       = start ? '0 : nx_q;
        ny       = start ? '0 : ny_q;
        dx       = start ? '0 : dx_q;
        dy       = start ? '0 : dy_q;
        // steps below 1.0 are clamped so a patch never owes more than one output
        stx_d    = start ? (i_step_x < ONE ? ONE : i_step_x) : stx_q;
        sty_d    = start ? (i_step_y < ONE ? ONE : i_step_y) : sty_q;
        row_em   = PI'(sy) == ny[PW-1:FRAC] && dy < DYW'(DST_H);
        col_em   = act & row_em & (PI'(sx) == nx[PW-1:FRAC]) & (dx < DXW'(DST_W));
        row_end  = sx == XW'(SRC_W - 1);
        row_done = row_end & row_em;
        last_col = dx == DXW'(DST_W - 1) || {1'b0, nx} + (PW+1)'(stx_d) >= (PW+1)'(SRC_W << FRAC);
        last_row = dy == DYW'(DST_H - 1) || {1'b0, ny} + (PW+1)'(sty_d) >= (PW+1)'(SRC_H << FRAC);
        state_d  = act ? (row_end && sy == YW'(SRC_H - 1) ? IDLE : RUN) : state_q;
        sx_d     = act ? (row_end ? '0 : sx + 1'b1) : sx;
        sy_d     = act & row_end ? sy + 1'b1 : sy;
        nx_d     = act & row_end ? '0 : col_em ? nx + PW'(stx_d) : nx;
        ny_d     = act & row_done ? ny + PW'(sty_d) : ny;
        dx_d     = act & row_done ? '0 : col_em ? dx + 1'b1 : dx;
        dy_d     = act & row_done ? dy + 1'b1 : dy;
        v_d      = ny[FRAC-1:0];
        err_d    = start & state_q == RUN;
        mk_d     = {mk_q[LAT-2:0], {col_em, col_em & dx == '0 & dy == '0,
                                    col_em & last_col, col_em & last_col & last_row}};
`ifdef BILINEAR_ROUND_EN
        rnd      = (PIX_W+1)'(({1'b0, acc} + (AW+1)'(1 << (2 * FRAC - 1))) >> (2 * FRAC));
`else
        rnd      = (PIX_W+1)'({1'b0, acc} >> (2 * FRAC));
`endif
        data_d   = rnd[PIX_W] ? '1 : rnd[PIX_W-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            sx_q    <= '0;
            sy_q    <= '0;
            nx_q    <= '0;
            ny_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            stx_q   <= '0;
            sty_q   <= '0;
            v_q     <= '0;
            err_q   <= 1'b0;
            mk_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            stx_q   <= stx_d;
            sty_q   <= sty_d;
            v_q     <= v_d;
            err_q   <= err_d;
            mk_q    <= mk_d;
            data_q  <= data_d;
        end
    end

    bilinear_lerp #(.W(PIX_W), .F(FRAC)) u_top (
        .i_clk(i_clk), .i_rst(i_rst), .i_a(i_patch[PIX_W-1:0]),
        .i_b(i_patch[3*PIX_W-1:2*PIX_W]), .i_w(nx[FRAC-1:0]), .o_y(top)
    );
    bilinear_lerp #(.W(PIX_W), .F(FRAC)) u_bot (
        .i_clk(i_clk), .i_rst(i_rst), .i_a(i_patch[2*PIX_W-1:PIX_W]),
        .i_b(i_patch[4*PIX_W-1:3*PIX_W]), .i_w(nx[FRAC-1:0]), .o_y(bot)
    );
    bilinear_lerp #(.W(PIX_W + FRAC), .F(FRAC)) u_vert (
        .i_clk(i_clk), .i_rst(i_rst), .i_a(top), .i_b(bot), .i_w(v_q), .o_y(acc)
    );

    assign o_data  = data_q;
    assign o_valid = mk_q[LAT-1][3];
    assign o_sof   = mk_q[LAT-1][2];
    assign o_eol   = mk_q[LAT-1][1];
    assign o_eof   = mk_q[LAT-1][0];
    assign o_err   = err_q;
endmodule
